// File: rtl/johnson_ctrl_pkg.sv
// johnson_ctrl_pkg: shared state encoding, reset pattern and phase decode for the Johnson step controller
package johnson_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] JC_RESET_STATE = 4'b0001;

    function automatic logic [2:0] jc_phase(input logic [3:0] q);
        case (q)
            4'b0001: return 3'd0;
            4'b0011: return 3'd1;
            4'b0111: return 3'd2;
            4'b1111: return 3'd3;
            4'b1110: return 3'd4;
            4'b1100: return 3'd5;
            4'b1000: return 3'd6;
            4'b0000: return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic jc_legal(input logic [3:0] q);
        return q == JC_RESET_STATE || jc_phase(q) != 3'd0;
    endfunction

endpackage

// File: rtl/johnson_stage.sv
// johnson_stage: 4-bit Johnson register with illegal-state recovery; reverse stepping under JOHNSON_CTRL_REVERSE_EN
import johnson_ctrl_pkg::*;

module johnson_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       rev,
    output logic [3:0] q
);

    logic [3:0] nxt;

`ifdef JOHNSON_CTRL_REVERSE_EN
    // next pattern in the selected direction, or the reset pattern if q has left the ring
    always_comb nxt = !jc_legal(q) ? JC_RESET_STATE : rev ? {~q[0], q[3:1]} : {q[2:0], ~q[3]};
`else
    logic unused_rev;
    assign unused_rev = rev;
    // forward-only next pattern, or the reset pattern if q has left the ring
    always_comb nxt = !jc_legal(q) ? JC_RESET_STATE : {q[2:0], ~q[3]};
`endif

    // q only moves on a step request and is otherwise held across runs
    always_ff @(posedge clk) begin
        if (rst) q <= JC_RESET_STATE;
        else if (step) q <= nxt;
    end

endmodule

// File: rtl/johnson_step_ctrl.sv
// johnson_step_ctrl: runs a Johnson stage for N steps or continuously at a programmable rate; JOHNSON_CTRL_REVERSE_EN enables dir
import johnson_ctrl_pkg::*;

module johnson_step_ctrl #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    input  logic [DIV_W-1:0] div,
    input  logic             dir,
    input  logic             stop,
    output logic [3:0]       q,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             step_stb,
    output logic             done
);

    state_t           state;
    logic [DIV_W-1:0] div_l, div_cnt;
    logic [CNT_W-1:0] remaining;
    logic             cont, step, rev;

    assign step  = state == RUN && !stop && div_cnt == '0;
    assign busy  = state != IDLE;
    assign done  = state == DONE;
    assign phase = jc_phase(q);

`ifdef JOHNSON_CTRL_REVERSE_EN
    logic dir_l;
    // direction is frozen for the whole run
    always_ff @(posedge clk) begin
        if (rst) dir_l <= 1'b0;
        else if (state == IDLE && start && !stop) dir_l <= dir;
    end
    assign rev = dir_l;
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign rev = 1'b0;
`endif

    // run FSM with rate divider and step counter; a stop always wins over a due step
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_l     <= '0;
            div_cnt   <= '0;
            remaining <= '0;
            cont      <= 1'b0;
            step_stb  <= 1'b0;
        end else begin
            step_stb <= step;
            if (state == IDLE) begin
                if (start && !stop) begin
                    state     <= RUN;
                    div_l     <= div;
                    div_cnt   <= div;
                    remaining <= steps;
                    cont      <= steps == '0;
                end
            end else if (state == RUN) begin
                if (stop) state <= DONE;
                else if (div_cnt == '0) begin
                    div_cnt <= div_l;
                    if (!cont) remaining <= remaining - 1'b1;
                    if (!cont && remaining == CNT_W'(1)) state <= DONE;
                end else div_cnt <= div_cnt - 1'b1;
            end else state <= IDLE;
        end
    end

    johnson_stage u_stage (
        .clk  (clk),
        .rst  (rst),
        .step (step),
        .rev  (rev),
        .q    (q)
    );

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// tb_johnson_step_ctrl: directed self-checking bench for johnson_step_ctrl
module tb_johnson_step_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] steps = '0;
    logic [7:0] div = '0;
    logic       dir = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] q;
    logic [2:0] phase;
    logic       busy, step_stb, done;

    int vec = 0;
    int err = 0;

    localparam logic [3:0] SEQ [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                       4'b1110, 4'b1100, 4'b1000, 4'b0000};

    johnson_step_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .steps    (steps),
        .div      (div),
        .dir      (dir),
        .stop     (stop),
        .q        (q),
        .phase    (phase),
        .busy     (busy),
        .step_stb (step_stb),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic launch(input logic [7:0] n, input logic [7:0] d, input logic r);
        steps = n;
        div = d;
        dir = r;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if (q !== 4'b0001) begin err++; $display("FAIL reset_q got %b want 0001", q); end
        vec++; if (phase !== 3'd0) begin err++; $display("FAIL reset_phase got %0d want 0", phase); end
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b want 0", busy); end
        vec++; if (step_stb !== 1'b0) begin err++; $display("FAIL reset_stb got %b want 0", step_stb); end
        vec++; if (done !== 1'b0) begin err++; $display("FAIL reset_done got %b want 0", done); end
    endtask

    task automatic test_counted();
        launch(8'd3, 8'd0, 1'b0);
        vec++; if (busy !== 1'b1 || q !== 4'b0001 || step_stb !== 1'b0) begin err++; $display("FAIL cnt_e0 got busy=%b q=%b stb=%b want 1 0001 0", busy, q, step_stb); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            vec++; if (q !== SEQ[k]) begin err++; $display("FAIL cnt_q_e%0d got %b want %b", k, q, SEQ[k]); end
            vec++; if (step_stb !== 1'b1) begin err++; $display("FAIL cnt_stb_e%0d got %b want 1", k, step_stb); end
            vec++; if (done !== (k == 3)) begin err++; $display("FAIL cnt_done_e%0d got %b want %b", k, done, k == 3); end
            vec++; if (busy !== 1'b1) begin err++; $display("FAIL cnt_busy_e%0d got %b want 1", k, busy); end
        end
        tick();
        vec++; if (busy !== 1'b0 || done !== 1'b0 || step_stb !== 1'b0 || q !== 4'b1111) begin err++; $display("FAIL cnt_e4 got busy=%b done=%b stb=%b q=%b want 0 0 0 1111", busy, done, step_stb, q); end
    endtask

    task automatic test_divider();
        logic [3:0] eq;
        do_reset();
        launch(8'd2, 8'd2, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            eq = k < 3 ? SEQ[0] : k < 6 ? SEQ[1] : SEQ[2];
            vec++; if (step_stb !== (k == 3 || k == 6)) begin err++; $display("FAIL div_stb_e%0d got %b want %b", k, step_stb, k == 3 || k == 6); end
            vec++; if (done !== (k == 6)) begin err++; $display("FAIL div_done_e%0d got %b want %b", k, done, k == 6); end
            vec++; if (q !== eq) begin err++; $display("FAIL div_q_e%0d got %b want %b", k, q, eq); end
        end
        vec++; if (busy !== 1'b0 || phase !== 3'd2) begin err++; $display("FAIL div_end got busy=%b phase=%0d want 0 2", busy, phase); end
    endtask

    task automatic test_continuous();
        int ns = 0;
        int nd = 0;
        do_reset();
        launch(8'd7, 8'd0, 1'b0);
        repeat (8) tick();
        vec++; if (q !== 4'b0000 || phase !== 3'd7 || busy !== 1'b0) begin err++; $display("FAIL cont_pre got q=%b phase=%0d busy=%b want 0000 7 0", q, phase, busy); end
        launch(8'd0, 8'd0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (step_stb) ns++;
            if (done) nd++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        vec++; if (step_stb !== 1'b0) begin err++; $display("FAIL cont_stop_stb got %b want 0", step_stb); end
        vec++; if (done !== 1'b1) begin err++; $display("FAIL cont_stop_done got %b want 1", done); end
        vec++; if (q !== 4'b0001 || phase !== 3'd0) begin err++; $display("FAIL cont_q got q=%b phase=%0d want 0001 0", q, phase); end
        if (done) nd++;
        tick();
        if (done) nd++;
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL cont_busy got %b want 0", busy); end
        vec++; if (ns !== 9) begin err++; $display("FAIL cont_steps got %0d want 9", ns); end
        vec++; if (nd !== 1) begin err++; $display("FAIL cont_done_cnt got %0d want 1", nd); end
    endtask

    task automatic test_back_to_back();
        int ns = 0;
        do_reset();
        steps = 8'd2;
        div = 8'd1;
        start = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            tick();
            if (step_stb) ns++;
        end
        start = 1'b0;
        vec++; if (busy !== 1'b0) begin err++; $display("FAIL b2b_busy_e5 got %b want 0", busy); end
        repeat (3) begin
            tick();
            if (step_stb) ns++;
        end
        vec++; if (ns !== 2 || q !== 4'b0111) begin err++; $display("FAIL b2b_steps got n=%0d q=%b want 2 0111", ns, q); end
        start = 1'b1;
        stop = 1'b1;
        tick();
        tick();
        start = 1'b0;
        stop = 1'b0;
        vec++; if (busy !== 1'b0 || q !== 4'b0111) begin err++; $display("FAIL b2b_startstop got busy=%b q=%b want 0 0111", busy, q); end
    endtask

    task automatic test_reverse();
        logic [3:0] eq;
        logic [2:0] ep;
        do_reset();
        launch(8'd3, 8'd0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick();
`ifdef JOHNSON_CTRL_REVERSE_EN
            ep = 3'(8 - k);
`else
            ep = 3'(k);
`endif
            eq = SEQ[ep];
            vec++; if (q !== eq || phase !== ep) begin err++; $display("FAIL rev_e%0d got q=%b phase=%0d want %b %0d", k, q, phase, eq, ep); end
        end
        tick();
    endtask

    task automatic test_reset_midrun();
        do_reset();
        launch(8'd5, 8'd0, 1'b0);
        tick();
        tick();
        vec++; if (q !== 4'b0111) begin err++; $display("FAIL mid_pre got %b want 0111", q); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec++; if (q !== 4'b0001 || busy !== 1'b0 || done !== 1'b0 || step_stb !== 1'b0 || phase !== 3'd0) begin err++; $display("FAIL mid_rst got q=%b busy=%b done=%b stb=%b want 0001 0 0 0", q, busy, done, step_stb); end
        launch(8'd1, 8'd0, 1'b0);
        tick();
        vec++; if (q !== 4'b0011 || done !== 1'b1 || step_stb !== 1'b1) begin err++; $display("FAIL mid_rerun got q=%b done=%b stb=%b want 0011 1 1", q, done, step_stb); end
        tick();
        vec++; if (busy !== 1'b0 || done !== 1'b0) begin err++; $display("FAIL mid_end got busy=%b done=%b want 0 0", busy, done); end
    endtask

    initial begin
        test_reset();
        test_counted();
        test_divider();
        test_continuous();
        test_back_to_back();
        test_reverse();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/johnson_step_ctrl.md
# johnson_step_ctrl

Sequencing controller for the team's 4-bit Johnson counter stage. It runs the stage for a requested number of steps, or continuously, at a programmable step rate. It provides start/stop control, a per-step strobe, a completion pulse and a decoded phase index. It sits between a host/sequencing FSM and any logic that consumes multi-phase Johnson outputs, such as phase enables or stepper drive.

## Interface
- CNT_W, default 8: width of the step-count request.
- DIV_W, default 8: width of the step-rate divider.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; accepted only in IDLE.
- steps  in  CNT_W  steps to perform; 0 = continuous; sampled on accepted start.
- div  in  DIV_W  step interval minus one (interval = div+1 clocks); sampled on accepted start.
- dir  in  1  0 = forward, 1 = reverse; sampled on accepted start; ignored unless JOHNSON_CTRL_REVERSE_EN.
- stop  in  1  abort request while running.
- q  out  4  Johnson stage state.
- phase  out  3  decoded index of q.
- busy  out  1  high in RUN and DONE.
- step_stb  out  1  one-cycle pulse on every edge where q advances.
- done  out  1  one-cycle pulse when a run ends (count reached or stopped).

## Operation
- Forward sequence: 0001→0011→0111→1111→1110→1100→1000→0000→0001; next = {q[2:0], ~q[3]}.
- Reverse sequence: next = {~q[0], q[3:1]} (0001→0000→1000→…).
- Any non-Johnson q value is replaced by 0001 on the next step.
- Phase decode: 0001=0, 0011=1, 0111=2, 1111=3, 1110=4, 1100=5, 1000=6, 0000=7. Non-Johnson values decode to 0.
- q is held between runs; it is not reloaded on start.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 and stop=0 → RUN. On that edge: latch steps, div, dir; load div_cnt=div and remaining=steps; set cont=(steps==0).
  - RUN: stop=1 → DONE. No step occurs on that edge, even if one is due.
  - RUN, div_cnt==0: advance q, reload div_cnt from the latched div, and decrement remaining unless cont. If !cont and remaining==1 → DONE.
  - RUN, div_cnt!=0: decrement div_cnt.
  - DONE: unconditionally → IDLE.
- start is ignored in RUN and DONE; no queuing.
- start and stop together in IDLE: stop wins, no run begins.
- In continuous mode, remaining is not decremented and only stop ends the run.

## Timing
- Reset values: q=0001, phase=0, busy=0, step_stb=0, done=0, state IDLE, div_cnt=0, remaining=0.
- Let E0 be the edge on which start is accepted.
  - First step occurs on edge E(div+1); later steps every div+1 edges.
  - A counted run of N steps makes its last step on edge E(N·(div+1)).
  - done is high for the cycle after the last step. busy falls one edge later.
- stop sampled on edge Ek: done is high in the cycle after Ek, and q keeps its pre-Ek value.
- step_stb is high in the cycle immediately after each edge where q changed.
- phase is combinational from q, so it updates in the same cycle as q.
- rst mid-run aborts immediately. All outputs take their reset values and no done pulse is issued.
- Counter widths: remaining is CNT_W bits, div_cnt is DIV_W bits. Neither counter wraps, because reload and exit happen at 0 and 1.

## Configuration
- JOHNSON_CTRL_REVERSE_EN defined: dir is latched at start and selects the forward or reverse next-state.
- Not defined: the reverse next-state logic and the latched-dir flop are not compiled. The dir port remains and is ignored, and every run steps forward.

## Structure
- Package johnson_ctrl_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the constant JC_RESET_STATE = 4'b0001;
  - the phase-decode function.
- Sub-module johnson_stage holds the 4-bit register:
  - inputs: clk, rst, step, rev;
  - output: q;
  - behaviour: forward/reverse next-state and illegal-state recovery.
- johnson_step_ctrl holds the FSM, divider, step counter and output pulses.

## Test plan
- Reset, then steps=3, div=0, dir=0, pulse start → q goes 0011, 0111, 1111 on E1–E3; step_stb high 3 cycles; done high one cycle after E3; busy low after E4.
- steps=2, div=2 → steps on E3 and E6 only; q ends at 0111; phase=2.
- steps=0 (continuous), div=0, stop asserted on E10 → exactly 9 steps, q=0001 after wrap (phase 0); done pulses once; no step on E10.
- start held high through RUN and DONE → no second run; start=1 with stop=1 in IDLE → busy stays 0.
- With JOHNSON_CTRL_REVERSE_EN: from q=0001, steps=3, dir=1 → q goes 0000, 1000, 1100; phase 7, 6, 5. Without the macro the same stimulus yields 0011, 0111, 1111.
- rst asserted during RUN at step 2 of 5 → next cycle q=0001, busy=0, done=0; a subsequent start runs normally.
